v_row_packer: RTL and testbench



---
 rtl/v_row_packer_pkg.sv | 35 +++
 rtl/v_row_packer_if.sv | 35 +++
 rtl/v_beat_assembler.sv | 62 ++++++
 rtl/v_row_packer.sv | 221 ++++++++++++++++++++++
 tb/tb_v_row_packer.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/v_row_packer_pkg.sv
// v_row_packer_pkg: shared types and constants for the V-row packer.
//   V_VECTOR_T     : one full V row (DIM*ELEM_W bits, element 0 in the LSBs)
//   beat_t         : one memory-controller beat (BEAT_W bits)
//   rows_t         : row count for one load command
//   V_PACK_STATE_T : packer control states
// NUM_ENTRIES follows `MAX_SEQ_LENGTH; a local default is supplied when the
// build does not define it.

`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 16
`endif

package v_row_packer_pkg;

    localparam int DIM           = 64;
    localparam int ELEM_W        = 8;
    localparam int BEAT_W        = 128;
    localparam int ROW_W         = DIM * ELEM_W;
    localparam int BEATS_PER_ROW = ROW_W / BEAT_W;
    localparam int NUM_ENTRIES   = `MAX_SEQ_LENGTH;
    localparam int ROWS_W        = $clog2(NUM_ENTRIES) + 1;
    localparam int BEAT_IDX_W    = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;

    typedef logic [ROW_W-1:0]  V_VECTOR_T;
    typedef logic [BEAT_W-1:0] beat_t;
    typedef logic [ROWS_W-1:0] rows_t;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PUSH,
        DONE
    } V_PACK_STATE_T;

endpackage

// File: rtl/v_row_packer_if.sv
// v_row_packer_if: beat input and row output handshakes of the packer.
//   mem_valid / mem_ready / mem_data        : beats from the memory controller
//   write_enable / sram_ready / write_data  : rows into the V-vector FIFO
// modport slave  : the packer itself
// modport master : the surrounding memory controller + FIFO

interface v_row_packer_if;
    import v_row_packer_pkg::*;

    logic      mem_valid;
    logic      mem_ready;
    beat_t     mem_data;
    logic      write_enable;
    logic      sram_ready;
    V_VECTOR_T write_data;

    modport slave (
        input  mem_valid,
        input  mem_data,
        input  sram_ready,
        output mem_ready,
        output write_enable,
        output write_data
    );

    modport master (
        output mem_valid,
        output mem_data,
        output sram_ready,
        input  mem_ready,
        input  write_enable,
        input  write_data
    );

endinterface

// File: rtl/v_beat_assembler.sv
// v_beat_assembler: collects BEATS_PER_ROW beats into one row register.
//   clk, rst     : clock, synchronous active-high reset
//   beat_we      : a beat is being offered for this row this cycle
//   beat_data    : beat payload
//   release_row  : the completed row has been consumed; frees the buffer
//   row_data     : row register (beat k at [k*BEAT_W +: BEAT_W])
//   full         : all beats of the row are present
//   last_beat    : the next accepted beat completes the row
// Beats are ignored while full so a row waiting to be written stays stable.

module v_beat_assembler
    import v_row_packer_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      beat_we,
    input  beat_t     beat_data,
    input  logic      release_row,
    output V_VECTOR_T row_data,
    output logic      full,
    output logic      last_beat
);

    logic [BEAT_IDX_W-1:0]    beat_idx;
    logic [BEATS_PER_ROW-1:0] slice_we;
    logic                     take;

    assign take      = beat_we & ~full;
    assign last_beat = (beat_idx == BEAT_IDX_W'(BEATS_PER_ROW - 1));

    always_comb begin
        slice_we = '0;
        for (int k = 0; k < BEATS_PER_ROW; k++) begin
            slice_we[k] = take && (beat_idx == BEAT_IDX_W'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_data <= '0;
            beat_idx <= '0;
            full     <= 1'b0;
        end else begin
            for (int k = 0; k < BEATS_PER_ROW; k++) begin
                if (slice_we[k]) begin
                    row_data[k*BEAT_W +: BEAT_W] <= beat_data;
                end
            end
            if (take) begin
                if (last_beat) begin
                    beat_idx <= '0;
                    full     <= 1'b1;
                end else begin
                    beat_idx <= beat_idx + 1'b1;
                end
            end else if (release_row) begin
                full <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/v_row_packer.sv
// v_row_packer: packs memory beats into full V rows and pushes them to the
// V-vector FIFO, a programmed number of rows per start command.
//   clk, rst  : clock, synchronous active-high reset
//   start     : one-cycle load command, honoured only in IDLE
//   num_rows  : rows to load, sampled with start
//   busy      : high in every state except IDLE
//   done      : one-cycle pulse after the last row is written
//   bus       : beat input / row output handshakes (v_row_packer_if.slave)
// Build option V_PACK_PINGPONG_EN: two row buffers so filling row n+1
// overlaps pushing row n. Without it a single buffer alternates FILL/PUSH.
//
// state | meaning
// IDLE  | waiting for start
// FILL  | accepting beats (pingpong: also pushing completed rows)
// PUSH  | full row offered to the FIFO (single buffer only)
// DONE  | done pulse, back to IDLE next cycle

module v_row_packer
    import v_row_packer_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  start,
    input  rows_t num_rows,
    output logic  busy,
    output logic  done,
    v_row_packer_if.slave bus
);

    V_PACK_STATE_T state;
    rows_t         rows_left;
    logic          mem_ready_q;
    logic          beat_xfer;
    logic          write_fire;

    // Outputs are masked during reset so nothing transfers in the reset cycle.
    assign bus.mem_ready = mem_ready_q & ~rst;
    assign beat_xfer     = bus.mem_valid & bus.mem_ready;
    assign write_fire    = bus.write_enable & bus.sram_ready;

`ifdef V_PACK_PINGPONG_EN

    rows_t     rows_to_fill;
    logic      fill_sel;
    logic      push_sel;
    logic      we_q;
    logic      row_complete;
    logic      fill_sel_nxt;
    logic      push_sel_nxt;
    rows_t     rows_to_fill_nxt;
    logic [1:0] full;
    logic [1:0] last;
    logic [1:0] full_nxt;
    V_VECTOR_T row_q [2];

    for (genvar i = 0; i < 2; i++) begin : g_buf
        v_beat_assembler u_asm (
            .clk         (clk),
            .rst         (rst),
            .beat_we     (beat_xfer && (fill_sel == 1'(i))),
            .beat_data   (bus.mem_data),
            .release_row (write_fire && (push_sel == 1'(i))),
            .row_data    (row_q[i]),
            .full        (full[i]),
            .last_beat   (last[i])
        );
    end

    assign bus.write_enable = we_q & ~rst;
    assign bus.write_data   = row_q[push_sel];

    // Fill and push pointers both alternate, so rows leave in acceptance order
    // and the buffer being filled is never the one being pushed.
    assign row_complete     = beat_xfer & last[fill_sel];
    assign fill_sel_nxt     = fill_sel ^ row_complete;
    assign push_sel_nxt     = push_sel ^ write_fire;
    assign rows_to_fill_nxt = rows_to_fill - rows_t'(row_complete);

    always_comb begin
        full_nxt = full;
        if (row_complete) full_nxt[fill_sel] = 1'b1;
        if (write_fire)   full_nxt[push_sel] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            rows_left    <= '0;
            rows_to_fill <= '0;
            fill_sel     <= 1'b0;
            push_sel     <= 1'b0;
            mem_ready_q  <= 1'b0;
            we_q         <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rows_left    <= num_rows;
                        rows_to_fill <= num_rows;
                        fill_sel     <= 1'b0;
                        push_sel     <= 1'b0;
                        busy         <= 1'b1;
                        if (num_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= FILL;
                            mem_ready_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    fill_sel     <= fill_sel_nxt;
                    push_sel     <= push_sel_nxt;
                    rows_to_fill <= rows_to_fill_nxt;
                    // Stall beats only when the next buffer to fill still holds a row.
                    mem_ready_q  <= (rows_to_fill_nxt != '0) && !full_nxt[fill_sel_nxt];
                    we_q         <= full_nxt[push_sel_nxt];
                    if (write_fire) begin
                        rows_left <= rows_left - 1'b1;
                        if (rows_left == rows_t'(1)) begin
                            state       <= DONE;
                            done        <= 1'b1;
                            mem_ready_q <= 1'b0;
                            we_q        <= 1'b0;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`else

    V_VECTOR_T row_data;
    logic      row_full;
    logic      last_beat;

    v_beat_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .beat_we     (beat_xfer),
        .beat_data   (bus.mem_data),
        .release_row (write_fire),
        .row_data    (row_data),
        .full        (row_full),
        .last_beat   (last_beat)
    );

    // The buffer is full exactly while the FSM sits in PUSH, so its full flag
    // is the registered row-available signal.
    assign bus.write_enable = row_full & ~rst;
    assign bus.write_data   = row_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rows_left   <= '0;
            mem_ready_q <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        rows_left <= num_rows;
                        busy      <= 1'b1;
                        if (num_rows == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= FILL;
                            mem_ready_q <= 1'b1;
                        end
                    end
                end
                FILL: begin
                    if (beat_xfer && last_beat) begin
                        state       <= PUSH;
                        mem_ready_q <= 1'b0;
                    end
                end
                PUSH: begin
                    if (write_fire) begin
                        rows_left <= rows_left - 1'b1;
                        if (rows_left == rows_t'(1)) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state       <= FILL;
                            mem_ready_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`endif

endmodule

// File: tb/tb_v_row_packer.sv
// Testbench for v_row_packer: table of load commands with hand-chosen beat
// patterns, plus hand-written reset sequences.

module tb_v_row_packer;
    import v_row_packer_pkg::*;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    logic  start = 1'b0;
    rows_t num_rows = '0;
    logic  busy;
    logic  done;

    v_row_packer_if bus();

    v_row_packer dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .num_rows (num_rows),
        .busy     (busy),
        .done     (done),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        int run;
        int nrows;
        int stall;      // sram_ready low cycles on the first row
        bit gapped;     // mem_valid toggles 1-0-1-0
        int extra_at;   // >0: stray start after this many beats and in DONE
        int exp_writes;
        bit pp;         // check back-to-back pingpong timing
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [ROW_W-1:0] act, input logic [ROW_W-1:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h required %0h", name, act, exp);
        else n_pass++;
    endtask

    // Beat idx of a run: lane 0 byte is idx*0x11 (+run offset), upper lanes differ.
    function automatic beat_t beat_val(input int run, input int idx);
        beat_t b;
        for (int j = 0; j < BEAT_W / 8; j++) b[j*8 +: 8] = 8'(idx * 17 + run * 3 + j * 16);
        return b;
    endfunction

    function automatic V_VECTOR_T exp_row(input int run, input int r);
        V_VECTOR_T v;
        for (int k = 0; k < BEATS_PER_ROW; k++) v[k*BEAT_W +: BEAT_W] = beat_val(run, r * BEATS_PER_ROW + k);
        return v;
    endfunction

    task automatic run_load(input vec_t v);
        int acc = 0, writes = 0, done_cnt = 0, done_cyc = -1, cyc = 0;
        int last_beat_cyc = -1, first_acc_cyc = -1, last_write_cyc = -1, stall_left;
        bit prev_last = 0, lat_ok = 1, stall_ok = 1, mr_seen = 0, finished = 0, extra_sent = 0, offer;
        V_VECTOR_T held = '0;
        stall_left = v.stall;
        @(posedge clk); #1;
        check($sformatf("run%0d_idle_busy", v.run), busy, 0);
        start = 1; num_rows = rows_t'(v.nrows); bus.mem_valid = 0; bus.sram_ready = 1;
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            cyc++;
            start = 0;
            if (cyc == 1) check($sformatf("run%0d_busy_after_start", v.run), busy, 1);
            if (prev_last && !bus.write_enable) lat_ok = 0;
            if (bus.mem_ready) mr_seen = 1;
            if (done) begin
                done_cnt++; done_cyc = cyc;
                if (v.extra_at > 0) begin start = 1; num_rows = 3; end
            end
            bus.sram_ready = 1;
            if (bus.write_enable) begin
                if (stall_left > 0) begin
                    bus.sram_ready = 0;
                    if (stall_left == v.stall) held = bus.write_data;
                    else if (bus.write_data !== held) stall_ok = 0;
                    if (bus.mem_ready) stall_ok = 0;
                    stall_left--;
                end else begin
                    check($sformatf("run%0d_row%0d_data", v.run, writes), bus.write_data, exp_row(v.run, writes));
                    writes++; last_write_cyc = cyc;
                end
            end
            // one spare row of beats is offered; it must never be accepted
            offer = (acc < (v.nrows + 1) * BEATS_PER_ROW) && (!v.gapped || (cyc % 2 == 1));
            bus.mem_valid = offer;
            bus.mem_data  = beat_val(v.run, acc);
            prev_last = 0;
            if (offer && bus.mem_ready) begin
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
                last_beat_cyc = cyc;
                prev_last = (acc % BEATS_PER_ROW == BEATS_PER_ROW - 1);
                acc++;
            end
            if (v.extra_at > 0 && !extra_sent && acc == v.extra_at) begin
                extra_sent = 1; start = 1; num_rows = 5;
            end
            if (done_cnt > 0 && cyc >= done_cyc + 2) begin finished = 1; break; end
        end
        bus.mem_valid = 0; start = 0;
        if (!finished) begin
            n_checks++;
            $display("FAIL run%0d_timeout: done not seen within 400 cycles, got %0d writes", v.run, writes);
        end
        check($sformatf("run%0d_writes", v.run), writes, v.exp_writes);
        check($sformatf("run%0d_done_count", v.run), done_cnt, 1);
        check($sformatf("run%0d_beats_accepted", v.run), acc, v.exp_writes * BEATS_PER_ROW);
        check($sformatf("run%0d_we_after_last_beat", v.run), lat_ok, 1);
        check($sformatf("run%0d_busy_end", v.run), busy, 0);
        if (v.stall > 0) check($sformatf("run%0d_stall_hold", v.run), stall_ok, 1);
        if (v.nrows == 0) begin
            check($sformatf("run%0d_zero_mem_ready", v.run), mr_seen, 0);
            check($sformatf("run%0d_zero_done_cycle", v.run), done_cyc, 1);
        end else begin
            check($sformatf("run%0d_done_cycle", v.run), done_cyc, last_write_cyc + 1);
        end
        if (v.pp) begin
            check($sformatf("run%0d_beat_span", v.run), last_beat_cyc - first_acc_cyc, v.exp_writes * BEATS_PER_ROW - 1);
            check($sformatf("run%0d_last_write_cycle", v.run), last_write_cyc, last_beat_cyc + 1);
        end
    endtask

    task automatic reset_mid_fill();
        int acc = 0;
        @(posedge clk); #1;
        start = 1; num_rows = 1;
        for (int c = 0; c < 20 && acc < 2; c++) begin
            @(posedge clk); #1;
            start = 0;
            bus.mem_valid = 1; bus.mem_data = beat_val(9, acc);
            if (bus.mem_ready) acc++;
        end
        check("midfill_two_beats", acc, 2);
        @(posedge clk); #1;
        rst = 1; bus.mem_data = beat_val(9, 2);
        #1;
        check("rst_cycle_mem_ready", bus.mem_ready, 0);
        @(posedge clk); #1;
        rst = 0; bus.mem_valid = 0;
        check("midfill_rst_busy", busy, 0);
        check("midfill_rst_write_data", bus.write_data, '0);
        check("midfill_rst_write_enable", bus.write_enable, 0);
    endtask

    task automatic reset_in_push();
        int acc = 0;
        @(posedge clk); #1;
        start = 1; num_rows = 1; bus.sram_ready = 0;
        for (int c = 0; c < 20 && !bus.write_enable; c++) begin
            @(posedge clk); #1;
            start = 0;
            bus.mem_valid = (acc < BEATS_PER_ROW); bus.mem_data = beat_val(11, acc);
            if (bus.mem_valid && bus.mem_ready) acc++;
        end
        bus.mem_valid = 0;
        check("push_we_before_rst", bus.write_enable, 1);
        rst = 1; bus.sram_ready = 1;
        #1;
        check("rst_cycle_no_write", bus.write_enable, 0);
        @(posedge clk); #1;
        rst = 0;
        check("push_rst_busy", busy, 0);
        check("push_rst_write_enable", bus.write_enable, 0);
    endtask

    initial begin
        bus.mem_valid = 0; bus.mem_data = '0; bus.sram_ready = 1;
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_mem_ready", bus.mem_ready, 0);
        check("reset_write_enable", bus.write_enable, 0);
        check("reset_write_data", bus.write_data, '0);
        rst = 0;

`ifdef V_PACK_PINGPONG_EN
        vecs.push_back('{20, 4, 0, 1'b0, 0, 4, 1'b1});
        vecs.push_back('{21, 2, 0, 1'b1, 0, 2, 1'b0});
        vecs.push_back('{22, 0, 0, 1'b0, 0, 0, 1'b0});
`else
        vecs.push_back('{0, 1, 0,  1'b0, 0, 1, 1'b0});
        vecs.push_back('{1, 1, 10, 1'b0, 0, 1, 1'b0});
        vecs.push_back('{2, 3, 0,  1'b1, 0, 3, 1'b0});
        vecs.push_back('{3, 0, 0,  1'b0, 0, 0, 1'b0});
        vecs.push_back('{4, 2, 0,  1'b0, 5, 2, 1'b0});
        vecs.push_back('{5, 2, 3,  1'b1, 0, 2, 1'b0});
`endif
        foreach (vecs[i]) run_load(vecs[i]);

        reset_mid_fill();
        run_load('{10, 1, 0, 1'b0, 0, 1, 1'b0});
        reset_in_push();
        run_load('{12, 1, 0, 1'b0, 0, 1, 1'b0});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
